// File: rtl/axi_llc_tag_req_arb.sv
// Request arbiter in front of the LLC tag store: issues one BIST request after reset,
// then merges flush and lookup requests into a single registered valid/ready channel.
module axi_llc_tag_req_arb #(
  parameter int unsigned SetAssociativity = 4,
  parameter int unsigned IndexLength      = 8,
  parameter int unsigned TagLength        = 8,
  parameter bit          EnableBist       = 1'b1,
  // req_o layout, MSB first: {mode[1:0], indicator[SA], index[IL], tag[TL], dirty}
  localparam int unsigned ReqW = 2 + SetAssociativity + IndexLength + TagLength + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [SetAssociativity-1:0] spm_lock_i,
  input  logic [SetAssociativity-1:0] flushed_i,
  input  logic                        flush_valid_i,
  output logic                        flush_ready_o,
  input  logic [SetAssociativity-1:0] flush_way_i,
  input  logic [IndexLength-1:0]      flush_index_i,
  input  logic                        lookup_valid_i,
  output logic                        lookup_ready_o,
  input  logic [IndexLength-1:0]      lookup_index_i,
  input  logic [TagLength-1:0]        lookup_tag_i,
  input  logic                        lookup_dirty_i,
  output logic [ReqW-1:0]             req_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  input  logic                        bist_valid_i,
  input  logic [SetAssociativity-1:0] bist_res_i,
  output logic [SetAssociativity-1:0] bist_err_o,
  output logic                        bist_done_o
);

  localparam logic [1:0] MODE_LOOKUP = 2'd1;
  localparam logic [1:0] MODE_FLUSH  = 2'd2;
  localparam logic [1:0] MODE_BIST   = 2'd3;

  localparam logic [1:0] ST_BIST_REQ  = 2'd0;
  localparam logic [1:0] ST_BIST_WAIT = 2'd1;
  localparam logic [1:0] ST_IDLE      = 2'd2;

  typedef struct packed {
    logic [1:0]                  mode;
    logic [SetAssociativity-1:0] indicator;
    logic [IndexLength-1:0]      index;
    logic [TagLength-1:0]        tag;
    logic                        dirty;
  } store_req_t;

  logic [1:0]                  state;
  logic                        vld_p0;
  store_req_t                  req_p0;
  store_req_t                  next_req;
  store_req_t                  bist_req;
  logic                        last_lookup;
  logic [SetAssociativity-1:0] bist_err;
  logic                        bist_done;

  logic [SetAssociativity-1:0] avail;
  logic                        lookup_req;
  logic                        slot_free;
  logic                        open;
  logic                        grant_flush;
  logic                        grant_lookup;

  // A lookup is only presentable when at least one way is neither SPM-locked nor flushed.
  assign avail      = ~(spm_lock_i | flushed_i);
  assign lookup_req = lookup_valid_i & (|avail);
  assign slot_free  = !vld_p0 | ready_i;
  assign open       = (state == ST_IDLE) & slot_free;

  // last_lookup resets high so flush wins the first contested cycle.
  assign grant_flush  = open & flush_valid_i & (!lookup_req | last_lookup);
  assign grant_lookup = open & lookup_req & !grant_flush;

  assign flush_ready_o  = grant_flush;
  assign lookup_ready_o = grant_lookup;

  always_comb begin
    bist_req           = '0;
    bist_req.mode      = MODE_BIST;
    bist_req.indicator = '1;
  end

  always_comb begin
    next_req = '0;
    if (grant_flush) begin
      next_req.mode      = MODE_FLUSH;
      next_req.indicator = flush_way_i;
      next_req.index     = flush_index_i;
    end else begin
      next_req.mode      = MODE_LOOKUP;
      next_req.indicator = avail;
      next_req.index     = lookup_index_i;
      next_req.tag       = lookup_tag_i;
      next_req.dirty     = lookup_dirty_i;
    end
  end

  // Stage p0: single-entry output register and BIST sequencer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= EnableBist ? ST_BIST_REQ : ST_IDLE;
      vld_p0      <= 1'b0;
      req_p0      <= '0;
      last_lookup <= 1'b1;
      bist_err    <= '0;
      bist_done   <= 1'b0;
    end else begin
      case (state)
        ST_BIST_REQ: begin
          if (!vld_p0) begin
            vld_p0 <= 1'b1;
            req_p0 <= bist_req;
          end else if (ready_i) begin
            vld_p0 <= 1'b0;
            state  <= ST_BIST_WAIT;
          end
        end
        ST_BIST_WAIT: begin
          if (bist_valid_i) begin
            bist_err  <= bist_res_i;
            bist_done <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          bist_done <= 1'b1;
          if (grant_flush || grant_lookup) begin
            vld_p0      <= 1'b1;
            req_p0      <= next_req;
            last_lookup <= grant_lookup;
          end else if (ready_i) begin
            vld_p0 <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign valid_o     = vld_p0;
  assign req_o       = req_p0;
  assign bist_err_o  = bist_err;
  assign bist_done_o = bist_done;

`ifndef SYNTHESIS
  flush_way_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    flush_valid_i |-> $onehot(flush_way_i))
    else $fatal(1, "flush_way_i is not one-hot while flush_valid_i is high");

  single_grant: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(flush_ready_o && lookup_ready_o));

  held_while_stalled: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i) |=> (valid_o && $stable(req_o)));
`endif

endmodule
